// File: rtl/dlsc_cpu1_icache_fill_pkg.sv
// dlsc_cpu1_icache_fill_pkg
// Shared types for the icache refill/invalidate engine.
// Contents:
//   fill_state_t  FSM state encoding of dlsc_cpu1_icache_fill
package dlsc_cpu1_icache_fill_pkg;

   // Engine phases. INIT sweeps every tag invalid. IDLE waits for a miss.
   // CMD issues the line read. DATA collects beats. DONE reports completion.
   typedef enum logic [2:0] {
      ST_INIT = 3'd0,
      ST_IDLE = 3'd1,
      ST_CMD  = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4
   } fill_state_t;

endpackage

// File: rtl/dlsc_cpu1_icache_fill.sv
// dlsc_cpu1_icache_fill
// Refill and invalidate engine for one icache way. It owns the way's write port.
// On a miss it reads one aligned line from memory and writes it word by word.
// It then writes the line's tag. After reset, and on a flush request, it sweeps
// every tag to invalid.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   miss_valid/ready/addr         miss request from the lookup logic
//   miss_done, miss_err           completion pulse, with an error flag
//   flush                         invalidate-all request; held pending until serviced
//   busy                          high whenever the engine is not idle
//   mem_cmd_valid/ready/addr      line read command to memory
//   mem_rd_valid/ready/data/err   read-data beats from memory
//   wr_addr, wr_en, wr_data       data write into the way
//   wr_en_tag, wr_tag             tag write into the way; bit 0 of the tag is valid
module dlsc_cpu1_icache_fill
   import dlsc_cpu1_icache_fill_pkg::*;
#(
   parameter int ADDR = 30,
   parameter int SIZE = 9,
   parameter int LINE = 4,
   parameter int DATA = 32,
   parameter int TAG  = 22
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            miss_valid,
   output logic            miss_ready,
   input  logic [ADDR-1:0] miss_addr,
   output logic            miss_done,
   output logic            miss_err,
   input  logic            flush,
   output logic            busy,
   output logic            mem_cmd_valid,
   input  logic            mem_cmd_ready,
   output logic [ADDR-1:0] mem_cmd_addr,
   input  logic            mem_rd_valid,
   output logic            mem_rd_ready,
   input  logic [DATA-1:0] mem_rd_data,
   input  logic            mem_rd_err,
   output logic [SIZE-1:0] wr_addr,
   output logic            wr_en,
   output logic [DATA-1:0] wr_data,
   output logic            wr_en_tag,
   output logic [TAG-1:0]  wr_tag
);

   localparam int IDXW = SIZE - LINE;

   if (TAG != ADDR - SIZE + 1 || LINE >= SIZE) begin : g_param_check
      $error("dlsc_cpu1_icache_fill: need TAG == ADDR-SIZE+1 and LINE < SIZE");
   end

   fill_state_t           state, state_nxt;
   logic                  flush_pend;
   logic [IDXW-1:0]       sweep_idx;
   logic [LINE-1:0]       beat;
   logic [ADDR-LINE-1:0]  line_addr;
   logic                  err;

   logic                  wr_en_q;
   logic [DATA-1:0]       wr_data_q;
   logic [SIZE-1:0]       wr_addr_q;
   logic                  tag_en_q;
   logic [TAG-1:0]        tag_q;

   logic                  beat_acc;
   logic                  last_beat;
   logic                  miss_acc;
   logic                  miss_addr_unused;

   // The word offset of the miss address does not matter: the whole line is fetched.
   assign miss_addr_unused = ^miss_addr[LINE-1:0];

   assign beat_acc  = (state == ST_DATA) && mem_rd_valid;
   assign last_beat = beat_acc && (beat == '1);
   assign miss_acc  = (state == ST_IDLE) && !flush_pend && miss_valid;

   // State register. Reset lands in INIT, so every reset ends with a full tag sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. A pending flush beats a coincident miss in IDLE.
   // A flush that arrives during INIT restarts the sweep instead of finishing it.
   // Once a line command has been issued, the line always runs to DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (!flush && sweep_idx == '1) state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (flush_pend)      state_nxt = ST_INIT;
            else if (miss_valid) state_nxt = ST_CMD;
         end
         ST_CMD:  if (mem_cmd_ready) state_nxt = ST_DATA;
         ST_DATA: if (last_beat) state_nxt = ST_DONE;
         ST_DONE: state_nxt = flush_pend ? ST_INIT : ST_IDLE;
         default: state_nxt = ST_INIT;
      endcase
   end

   // Control registers: flush bookkeeping, the sweep index, the beat counter,
   // the latched line address and the sticky error.
   // flush_pend is dropped whenever a sweep is running or about to start.
   // That sweep also covers any flush that arrives at the same moment.
   // The sweep index wraps to zero on its last step, so a later INIT starts clean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_pend <= 1'b0;
         sweep_idx  <= '0;
         beat       <= '0;
         line_addr  <= '0;
         err        <= 1'b0;
      end else begin
         if (state == ST_INIT || state_nxt == ST_INIT) begin
            flush_pend <= 1'b0;
         end else if (flush) begin
            flush_pend <= 1'b1;
         end

         if (state == ST_INIT) begin
            sweep_idx <= flush ? '0 : sweep_idx + 1'b1;
         end else begin
            sweep_idx <= '0;
         end

         if (miss_acc) begin
            line_addr <= miss_addr[ADDR-1:LINE];
         end

         if (state == ST_CMD) begin
            beat <= '0;
            err  <= 1'b0;
         end else if (beat_acc) begin
            beat <= beat + 1'b1;
            if (mem_rd_err) err <= 1'b1;
         end
      end
   end

   // Write pipeline. Each accepted beat becomes a way write one cycle later.
   // The last beat also loads the tag, so the data word and the tag land in the same cycle.
   // The tag stays invalid until then, and an errored line is written back invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         wr_addr_q <= '0;
         tag_en_q  <= 1'b0;
         tag_q     <= '0;
      end else begin
         wr_en_q  <= beat_acc;
         tag_en_q <= last_beat;
         if (beat_acc) begin
            wr_data_q <= mem_rd_data;
            wr_addr_q <= {line_addr[IDXW-1:0], beat};
         end
         if (last_beat) begin
            tag_q <= {line_addr[ADDR-LINE-1:IDXW], ~(err | mem_rd_err)};
         end
      end
   end

   // Output decode. Everything is forced low while reset is held; this includes the INIT
   // tag strobe, so nothing reaches the way until reset is released.
   // INIT drives the sweep's tag writes directly. Every other state forwards the
   // registered write pipeline.
   always_comb begin
      miss_ready    = 1'b0;
      miss_done     = 1'b0;
      miss_err      = 1'b0;
      busy          = 1'b0;
      mem_cmd_valid = 1'b0;
      mem_cmd_addr  = '0;
      mem_rd_ready  = 1'b0;
      wr_addr       = '0;
      wr_en         = 1'b0;
      wr_data       = '0;
      wr_en_tag     = 1'b0;
      wr_tag        = '0;
      if (!rst) begin
         busy          = (state != ST_IDLE);
         miss_ready    = (state == ST_IDLE) && !flush_pend;
         miss_done     = (state == ST_DONE);
         miss_err      = (state == ST_DONE) && err;
         mem_cmd_valid = (state == ST_CMD);
         mem_cmd_addr  = {line_addr, {LINE{1'b0}}};
         mem_rd_ready  = (state == ST_DATA);
         wr_en         = wr_en_q;
         wr_data       = wr_data_q;
         if (state == ST_INIT) begin
            wr_en_tag = 1'b1;
            wr_tag    = '0;
            wr_addr   = {sweep_idx, {LINE{1'b0}}};
         end else begin
            wr_en_tag = tag_en_q;
            wr_tag    = tag_q;
            wr_addr   = wr_addr_q;
         end
      end
   end

endmodule

// File: tb/tb_dlsc_cpu1_icache_fill.sv
// tb_dlsc_cpu1_icache_fill
// Self-checking bench for dlsc_cpu1_icache_fill.
// The bench reads miss scenarios from a vector table. When it drives a data beat, it pushes
// the expected way write onto a scoreboard queue. A monitor pops the queue and compares it
// against every write the DUT issues.
// Hand-written sequences cover these cases: the reset sweep, a flush while idle, a flush
// in mid-line with a held miss, and reset asserted in mid-line.
module tb_dlsc_cpu1_icache_fill;

   localparam int ADDR  = 30;
   localparam int SIZE  = 9;
   localparam int LINE  = 4;
   localparam int DATA  = 32;
   localparam int TAG   = 22;
   localparam int BEATS = 1 << LINE;
   localparam int NIDX  = 1 << (SIZE - LINE);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            miss_valid, miss_ready, miss_done, miss_err, flush, busy;
   logic [ADDR-1:0] miss_addr;
   logic            mem_cmd_valid, mem_cmd_ready;
   logic [ADDR-1:0] mem_cmd_addr;
   logic            mem_rd_valid, mem_rd_ready, mem_rd_err;
   logic [DATA-1:0] mem_rd_data;
   logic [SIZE-1:0] wr_addr;
   logic            wr_en, wr_en_tag;
   logic [DATA-1:0] wr_data;
   logic [TAG-1:0]  wr_tag;

   always #5 clk = ~clk;

   dlsc_cpu1_icache_fill #(
      .ADDR(ADDR), .SIZE(SIZE), .LINE(LINE), .DATA(DATA), .TAG(TAG)
   ) dut (
      .clk(clk), .rst(rst),
      .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
      .miss_done(miss_done), .miss_err(miss_err), .flush(flush), .busy(busy),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
      .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
      .mem_rd_err(mem_rd_err),
      .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
      .wr_en_tag(wr_en_tag), .wr_tag(wr_tag)
   );

   typedef struct {
      logic [ADDR-1:0] addr;
      int              cmdDelay;
      bit              gaps;
      int              errBeat;
      int              flushBeat;
      int              abortBeat;
      logic [ADDR-1:0] expCmd;
      logic [SIZE-1:0] expBase;
      logic [TAG-1:0]  expTag;
      bit              expErr;
   } vec_t;

   typedef struct {
      logic [SIZE-1:0] addr;
      logic [DATA-1:0] data;
   } wr_exp_t;

   typedef struct {
      logic [SIZE-1:0] addr;
      logic [TAG-1:0]  tag;
   } tag_exp_t;

   vec_t     vecs[8];
   wr_exp_t  dataQ[$];
   tag_exp_t tagQ[$];
   wr_exp_t  monW;
   tag_exp_t monT;
   int       errorCount = 0;
   int       checkCount = 0;
   int       lastWaits = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit anyOut();
      return |{miss_ready, miss_done, miss_err, busy, mem_cmd_valid, mem_cmd_addr, mem_rd_ready,
               wr_addr, wr_en, wr_data, wr_en_tag, wr_tag};
   endfunction

   // Queue the invalidating tag write expected at every line index of a sweep.
   task automatic pushSweep();
      tag_exp_t t;
      for (int i = 0; i < NIDX; i++) begin
         t.addr = SIZE'(i << LINE);
         t.tag  = '0;
         tagQ.push_back(t);
      end
   endtask

   // Expect 32 consecutive sweep cycles. During the sweep the engine is busy and refuses misses;
   // after it the engine is idle and ready. With startNow set, the current cycle is the first
   // sweep cycle.
   task automatic checkSweep(input bit startNow);
      for (int i = 0; i < NIDX; i++) begin
         if (i > 0 || !startNow) begin
            @(negedge clk); #1;
         end
         checkOutput("sweep_cycle", {busy, wr_en_tag, miss_ready}, 3'b110);
      end
      @(negedge clk); #1;
      checkOutput("sweep_end", {busy, wr_en_tag, miss_ready}, 3'b001);
   endtask

   // Scoreboard monitor: every way write must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            if (dataQ.size() == 0) begin
               checkOutput("unexpected_wr_en", {wr_addr, 1'b1}, 64'h0);
            end else begin
               monW = dataQ.pop_front();
               checkOutput("wr_word", {wr_addr, wr_data}, {monW.addr, monW.data});
            end
         end
         if (wr_en_tag) begin
            if (tagQ.size() == 0) begin
               checkOutput("unexpected_wr_en_tag", {wr_addr, 1'b1}, 64'h0);
            end else begin
               monT = tagQ.pop_front();
               checkOutput("wr_tag", {wr_addr, wr_tag}, {monT.addr, monT.tag});
            end
         end
      end
   end

   // Run one miss from the table. The task is entered just after a falling edge
   // and returns just after a falling edge.
   task automatic applyStimulus(input int e, output bit aborted);
      vec_t     v;
      int       waits;
      int       beat;
      int       guard;
      bit       valid;
      wr_exp_t  w;
      tag_exp_t t;
      v = vecs[e];
      aborted = 1'b0;
      miss_valid = 1'b1;
      miss_addr  = v.addr;
      waits = 0;
      while (!miss_ready && waits < 200) begin
         @(negedge clk); #1;
         waits++;
      end
      lastWaits = waits;
      if (!miss_ready) begin
         checkOutput("miss_accept_timeout", 64'd0, 64'd1);
         miss_valid = 1'b0;
         return;
      end
      @(negedge clk); #1;
      miss_valid = 1'b0;
      miss_addr  = ADDR'($urandom);
      checkOutput("cmd_valid", {busy, mem_cmd_valid, miss_ready}, 3'b110);
      checkOutput("cmd_addr", mem_cmd_addr, v.expCmd);
      for (int d = 0; d < v.cmdDelay; d++) begin
         @(negedge clk); #1;
         checkOutput("cmd_addr_hold", {mem_cmd_valid, mem_cmd_addr}, {1'b1, v.expCmd});
      end
      mem_cmd_ready = 1'b1;
      @(negedge clk); #1;
      mem_cmd_ready = 1'b0;
      beat  = 0;
      guard = 0;
      while (beat < BEATS && guard < 500) begin
         if (beat == v.abortBeat) begin
            aborted = 1'b1;
            return;
         end
         valid        = !v.gaps || ($urandom_range(0, 2) != 0);
         mem_rd_valid = valid;
         mem_rd_data  = $urandom;
         mem_rd_err   = valid && (beat == v.errBeat);
         flush        = valid && (beat == v.flushBeat);
         checkOutput("rd_ready_in_data", {mem_rd_ready, mem_cmd_valid}, 2'b10);
         if (valid) begin
            w.addr = v.expBase + SIZE'(beat);
            w.data = mem_rd_data;
            dataQ.push_back(w);
            if (beat == BEATS - 1) begin
               t.addr = w.addr;
               t.tag  = v.expTag;
               tagQ.push_back(t);
            end
            beat++;
         end
         @(negedge clk); #1;
         guard++;
         flush = 1'b0;
      end
      mem_rd_valid = 1'b0;
      mem_rd_err   = 1'b0;
      if (beat < BEATS) begin
         checkOutput("beat_timeout", 64'd0, 64'd1);
         return;
      end
      checkOutput("done_pulse", {miss_done, miss_err, busy, mem_rd_ready}, {1'b1, v.expErr, 1'b1, 1'b0});
      if (v.flushBeat >= 0) pushSweep();
      @(negedge clk); #1;
      checkOutput("done_width", {miss_done, miss_err}, 2'b00);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not reach the end");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit ab;
      miss_valid    = 1'b0;
      miss_addr     = '0;
      flush         = 1'b0;
      mem_cmd_ready = 1'b0;
      mem_rd_valid  = 1'b0;
      mem_rd_data   = '0;
      mem_rd_err    = 1'b0;
      rst           = 1'b1;

      //           addr           dly gap errB flB abB expCmd         base    tag         err
      vecs[0] = '{30'h1234567,    3, 1'b0, -1, -1, -1, 30'h1234560,    9'h160, 22'h012345, 1'b0};
      vecs[1] = '{30'h3FFFFFFF,   0, 1'b1, -1, -1, -1, 30'h3FFFFFF0,   9'h1F0, 22'h3FFFFF, 1'b0};
      vecs[2] = '{30'h000000A,    1, 1'b0,  5, -1, -1, 30'h0000000,    9'h000, 22'h000000, 1'b1};
      vecs[3] = '{30'h0ABCDEF,    2, 1'b1, 15, -1, -1, 30'h0ABCDE0,    9'h1E0, 22'h00ABCC, 1'b1};
      vecs[4] = '{30'h2468ACE,    1, 1'b1, -1,  8, -1, 30'h2468AC0,    9'h0C0, 22'h02468B, 1'b0};
      vecs[5] = '{30'h0000155,    0, 1'b0, -1, -1, -1, 30'h0000150,    9'h150, 22'h000001, 1'b0};
      vecs[6] = '{30'h1000000,    0, 1'b0, -1, -1,  6, 30'h1000000,    9'h000, 22'h010001, 1'b0};
      vecs[7] = '{30'h0FEDCBA,    2, 1'b1, -1, -1, -1, 30'h0FEDCB0,    9'h0B0, 22'h00FEDD, 1'b0};

      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_outputs_zero", {63'd0, anyOut()}, 64'd0);

      pushSweep();
      @(posedge clk); #2;
      rst = 1'b0;
      checkSweep(1'b0);

      for (int e = 0; e < 4; e++) begin
         applyStimulus(e, ab);
      end

      flush = 1'b1;
      @(negedge clk); #1;
      flush      = 1'b0;
      miss_valid = 1'b1;
      miss_addr  = vecs[0].addr;
      checkOutput("flush_pend_blocks_miss", {miss_ready, busy}, 2'b00);
      pushSweep();
      checkSweep(1'b0);
      applyStimulus(0, ab);
      checkOutput("miss_after_flush_waits", lastWaits, 64'd0);

      applyStimulus(4, ab);
      miss_valid = 1'b1;
      miss_addr  = vecs[5].addr;
      checkSweep(1'b1);
      applyStimulus(5, ab);
      checkOutput("held_miss_waits", lastWaits, 64'd0);

      applyStimulus(6, ab);
      checkOutput("abort_point_reached", {63'd0, ab}, 64'd1);
      mem_rd_valid = 1'b0;
      mem_rd_err   = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("reset_mid_data_zero", {63'd0, anyOut()}, 64'd0);
      dataQ.delete();
      tagQ.delete();
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_hold_zero", {63'd0, anyOut()}, 64'd0);
      pushSweep();
      @(posedge clk); #2;
      rst = 1'b0;
      checkSweep(1'b0);
      applyStimulus(7, ab);

      @(negedge clk); #1;
      checkOutput("idle_quiet", {busy, mem_cmd_valid, mem_rd_ready, wr_en, wr_en_tag}, 5'b00000);
      checkOutput("data_queue_drained", dataQ.size(), 64'd0);
      checkOutput("tag_queue_drained", tagQ.size(), 64'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
